// File: rtl/ax_rt_unit_gate.sv
// AX-channel gate: blocks new AX on budget exhaustion, outstanding limit or isolation,
// while keeping an already-presented AX valid until it is accepted downstream.
module ax_rt_unit_gate #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned BytesWidth     = 16,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  budget_spent_i,
  input  logic                  isolate_i,
  input  logic                  slv_ax_valid_i,
  output logic                  slv_ax_ready_o,
  input  logic [7:0]            slv_ax_len_i,
  input  logic [2:0]            slv_ax_size_i,
  output logic                  mst_ax_valid_o,
  input  logic                  mst_ax_ready_i,
  input  logic                  rsp_done_i,
  output logic [BytesWidth-1:0] ax_bytes_o,
  output logic                  ax_happening_o,
  output logic [CntWidth-1:0]   outstanding_o,
  output logic                  gated_o,
  output logic                  isolated_o
);

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } state_e;

  state_e                state_q;
  logic                  pending_q, pending_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  isolated_q;
  logic                  at_max;
  logic                  block_new;
  logic                  mst_valid;
  logic                  handshake;
  logic                  done_eff;
  logic [BytesWidth-1:0] beats;

  assign at_max    = (cnt_q == CntWidth'(MaxOutstanding));
  assign block_new = (enable_i & budget_spent_i) | isolate_i | at_max | (state_q != PASS);
  // A presented-but-unaccepted AX stays valid whatever the gate decides.
  assign mst_valid = pending_q | (slv_ax_valid_i & ~block_new);
  assign handshake = mst_valid & mst_ax_ready_i;

  assign beats          = BytesWidth'(slv_ax_len_i) + BytesWidth'(1);
  assign ax_bytes_o     = beats << slv_ax_size_i;
  assign mst_ax_valid_o = mst_valid;
  assign slv_ax_ready_o = handshake;
  assign ax_happening_o = handshake;
  assign gated_o        = block_new & ~pending_q;
  assign outstanding_o  = cnt_q;
  assign isolated_o     = isolated_q;

  // Outstanding count and valid-hold tracking; responses at zero are stale and dropped.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = mst_valid & ~mst_ax_ready_i;
    done_eff  = rsp_done_i && (cnt_q != '0);
    if (handshake && !done_eff && !at_max) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (done_eff && !handshake) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PASS;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      isolated_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      isolated_q <= 1'b0;
      case (state_q)
        PASS: begin
          if (isolate_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!isolate_i) begin
            state_q <= PASS;
          end else if ((cnt_q == '0) && !pending_q) begin
            state_q    <= ISOLATED;
            isolated_q <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_i) begin
            state_q <= PASS;
          end else begin
            isolated_q <= 1'b1;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

endmodule

// File: doc/ax_rt_unit_gate.md
AX_RT_UNIT_GATE -- requirements
Module: ax_rt_unit_gate

Interface
REQ-001: Parameter MaxOutstanding, default 8, SHALL set the maximum in-flight AX transactions (>=1).
REQ-002: Parameter BytesWidth, default 16, SHALL set the ax_bytes_o width (>=16).
REQ-003: Parameter CntWidth, default $clog2(MaxOutstanding+1), SHALL set the outstanding_o width.
REQ-004: clk_i  in  1  sole clock, all state on rising edge.
REQ-005: rst_i  in  1  reset, synchronous, active-high.
REQ-006: enable_i  in  1  budget gating enable.
REQ-007: budget_spent_i  in  1  budget exhausted, from the counter unit.
REQ-008: isolate_i  in  1  isolation request.
REQ-009: slv_ax_valid_i / slv_ax_ready_o  in/out  1  upstream AX handshake.
REQ-010: slv_ax_len_i  in  8  AXI burst length minus one.
REQ-011: slv_ax_size_i  in  3  AXI beat size code.
REQ-012: mst_ax_valid_o / mst_ax_ready_i  out/in  1  downstream AX handshake.
REQ-013: rsp_done_i  in  1  one transaction completed (B handshake or R-last handshake).
REQ-014: ax_bytes_o  out  BytesWidth  bytes of the current AX.
REQ-015: ax_happening_o  out  1  downstream AX handshake this cycle.
REQ-016: outstanding_o  out  CntWidth  in-flight transaction count.
REQ-017: gated_o  out  1  new AX currently blocked.
REQ-018: isolated_o  out  1  isolation complete.

Function
REQ-019: ax_bytes_o SHALL equal (slv_ax_len_i+1) << slv_ax_size_i, zero-extended, combinationally (max 32768).
REQ-020: ax_happening_o SHALL equal mst_ax_valid_o & mst_ax_ready_i, same cycle, zero latency.
REQ-021: block_new SHALL be (enable_i & budget_spent_i) | isolate_i | (outstanding_o == MaxOutstanding) | (state != PASS).
REQ-022: gated_o SHALL equal block_new & !pending.
REQ-023: pending SHALL set when mst_ax_valid_o=1 and mst_ax_ready_i=0, and SHALL clear on the downstream handshake.
REQ-024: While pending=1, mst_ax_valid_o SHALL be 1 regardless of block_new (AXI valid stability).
REQ-025: Otherwise, mst_ax_valid_o SHALL equal slv_ax_valid_i & !block_new.
REQ-026: slv_ax_ready_o SHALL equal mst_ax_ready_i & mst_ax_valid_o.
REQ-027: outstanding_o SHALL increment on ax_happening_o and decrement on rsp_done_i; if both occur in one cycle it SHALL be unchanged.
REQ-028: rsp_done_i while outstanding_o==0 SHALL be ignored (no wrap).
REQ-029: A handshake completing a pending AX while outstanding_o==MaxOutstanding-1 SHALL be allowed; the count SHALL never exceed MaxOutstanding.
REQ-030: The FSM SHALL have states PASS, DRAIN and ISOLATED.
REQ-031: PASS->DRAIN when isolate_i=1.
REQ-032: DRAIN->ISOLATED when outstanding_o==0, pending==0 and isolate_i=1.
REQ-033: DRAIN->PASS when isolate_i=0.
REQ-034: ISOLATED->PASS when isolate_i=0.
REQ-035: isolated_o SHALL be 1 only in ISOLATED, registered, reached at least 1 cycle after isolate_i rises.
REQ-036: enable_i=0 SHALL disable budget gating only; isolation and the outstanding limit SHALL remain active.

Reset
REQ-037: On rst_i=1 at a clock edge: state=PASS, pending=0, outstanding_o=0, isolated_o=0.
REQ-038: Reset mid-transaction SHALL drop all tracking; responses for pre-reset transactions SHALL be ignored per REQ-028.

Verification
REQ-039: Budget gate: len=3, size=2, handshake -> ax_bytes_o=16 and ax_happening_o=1 that cycle; budget_spent_i=1 with enable_i=1 -> mst_ax_valid_o=0 and gated_o=1 next AX.
REQ-040: Valid stability: valid asserted, ready=0, then budget_spent_i=1 -> mst_ax_valid_o stays 1 until ready, then gates.
REQ-041: Limit: MaxOutstanding=2, two AX with no responses -> third AX blocked; one rsp_done_i -> third AX passes.
REQ-042: Isolation: 3 outstanding, isolate_i=1 -> DRAIN; after 3 rsp_done_i -> isolated_o=1 next cycle; isolate_i=0 -> PASS, isolated_o=0.
REQ-043: Simultaneous handshake and rsp_done_i at count 1 -> count stays 1; rsp_done_i at count 0 -> stays 0.
REQ-044: rst_i pulse with 2 outstanding in DRAIN -> outstanding_o=0, isolated_o=0, state PASS next cycle.
